// File: rtl/sum_bcd_converter.sv
// Sequential binary-to-packed-BCD converter (double-dabble, one bit per clock).
// It accepts one value over valid/ready, pulses out_valid when done and holds the result.
module sum_bcd_converter #(
  parameter int IN_WIDTH = 7,
  parameter int DIGITS   = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [IN_WIDTH-1:0]   in_data,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [1:0]            dbg_state_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + IN_WIDTH;
  localparam int CNT_W = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Handshake: a value transfers on a rising edge where in_valid and in_ready are
  // both high; in_ready is high only in IDLE and nothing is queued while it is low.
  state_t              state_q, state_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [SR_W-1:0]     adj;
  logic [SR_W-1:0]     shifted;

  // Add-3 correction on every BCD field from pre-shift values, then shift left.
  always_comb begin
    adj = sr_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (sr_q[IN_WIDTH + 4*d +: 4] >= 4'd5) begin
        adj[IN_WIDTH + 4*d +: 4] = sr_q[IN_WIDTH + 4*d +: 4] + 4'd3;
      end
    end
    shifted = {adj[SR_W-2:0], 1'b0};
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sr_d    = {{BCD_W{1'b0}}, in_data};
          cnt_d   = CNT_W'(IN_WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy  = 1'b1;
        sr_d  = shifted;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = shifted[SR_W-1 -: BCD_W];
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sum_bcd_converter.sv
// Self-checking bench for sum_bcd_converter: directed scenarios, a full input
// sweep and randomized traffic, all checked against an arithmetic decimal model.
module tb_sum_bcd_converter;

  localparam int IN_WIDTH = 7;
  localparam int DIGITS   = 3;
  localparam int BCD_W    = 4 * DIGITS;

  logic               clock;
  logic               reset;
  logic               in_valid;
  logic [IN_WIDTH-1:0] in_data;
  logic               in_ready;
  logic               busy;
  logic               out_valid;
  logic [BCD_W-1:0]   bcd_out;
  logic [1:0]         dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [BCD_W-1:0] exp_q[$];

  sum_bcd_converter #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .busy       (busy),
    .out_valid  (out_valid),
    .bcd_out    (bcd_out),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Decimal digits by plain division: the reference for every result.
  function automatic logic [BCD_W-1:0] to_bcd(input int v);
    logic [BCD_W-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Inputs change and outputs are sampled 1 time unit after a rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Driver: one conversion with full latency, hold and pulse-width checks.
  task automatic do_convert(input logic [IN_WIDTH-1:0] v, input string tag);
    logic [BCD_W-1:0] prev_bcd;
    logic [BCD_W-1:0] exp;
    int lat, ready_low, dec, p;
    bit held_ok;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before_accept: got %b want 1", tag, in_ready);
    end
    prev_bcd = bcd_out;
    in_valid = 1'b1;
    in_data  = v;
    exp_q.push_back(to_bcd(int'(v)));
    step();
    in_valid = 1'b0;
    lat = 0;
    ready_low = 0;
    held_ok = 1'b1;
    while (out_valid !== 1'b1 && lat < 20) begin
      if (in_ready === 1'b0) ready_low++;
      if (bcd_out !== prev_bcd) held_ok = 1'b0;
      in_data = IN_WIDTH'($urandom_range(0, (1 << IN_WIDTH) - 1));
      step();
      lat++;
    end
    if (in_ready === 1'b0) ready_low++;
    exp = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s out_valid_timeout: got no pulse within %0d cycles, want one at 7", tag, lat);
      return;
    end
    checks++;
    if (lat != IN_WIDTH) begin
      failures++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, IN_WIDTH);
    end
    checks++;
    if (bcd_out !== exp) begin
      failures++;
      $display("FAIL %s bcd_out: got %h want %h", tag, bcd_out, exp);
    end
    dec = 0;
    p = 1;
    for (int d = 0; d < DIGITS; d++) begin
      checks++;
      if (bcd_out[4*d +: 4] > 4'd9) begin
        failures++;
        $display("FAIL %s nibble%0d_range: got %0d want <=9", tag, d, bcd_out[4*d +: 4]);
      end
      dec = dec + int'(bcd_out[4*d +: 4]) * p;
      p = p * 10;
    end
    checks++;
    if (dec != int'(v)) begin
      failures++;
      $display("FAIL %s decode: got %0d want %0d", tag, dec, v);
    end
    checks++;
    if (ready_low != IN_WIDTH + 1 || !held_ok || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s ready_hold_busy: ready_low=%0d held=%0b busy=%b want 8 1 0",
               tag, ready_low, held_ok, busy);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || bcd_out !== exp) begin
      failures++;
      $display("FAIL %s after_done: out_valid=%b in_ready=%b bcd=%h want 0 1 %h",
               tag, out_valid, in_ready, bcd_out, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    step();
    step();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || bcd_out !== '0) begin
      failures++;
      $display("FAIL reset_state: ready=%b busy=%b ov=%b bcd=%h want 1 0 0 000",
               in_ready, busy, out_valid, bcd_out);
    end
    reset = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd_out !== '0) begin
      failures++;
      $display("FAIL reset_idle: ready=%b ov=%b bcd=%h want 1 0 000", in_ready, out_valid, bcd_out);
    end
  endtask

  task automatic test_single();
    do_convert(7'd15, "single15");
    do_convert(7'd120, "single120");
    do_convert(7'd127, "single127");
    do_convert(7'd0, "single0");
  endtask

  task automatic test_back_to_back();
    int cyc, n_acc, n_res;
    int acc_cyc[2];
    bit prev_ready;
    logic [BCD_W-1:0] exp;
    prev_ready = in_ready;
    in_valid = 1'b1;
    in_data = 7'd15;
    cyc = 0;
    n_acc = 0;
    n_res = 0;
    while (n_res < 2 && cyc < 40) begin
      step();
      cyc++;
      if (prev_ready && in_valid) begin
        acc_cyc[n_acc] = cyc;
        exp_q.push_back(to_bcd(int'(in_data)));
        n_acc++;
        if (n_acc == 1) in_data = 7'd120;
        else in_valid = 1'b0;
      end
      if (out_valid === 1'b1) begin
        exp = exp_q.pop_front();
        checks++;
        if (bcd_out !== exp) begin
          failures++;
          $display("FAIL b2b_result%0d: got %h want %h", n_res, bcd_out, exp);
        end
        n_res++;
      end
      prev_ready = in_ready;
    end
    in_valid = 1'b0;
    checks++;
    if (n_res != 2 || n_acc != 2) begin
      failures++;
      $display("FAIL b2b_count: results=%0d accepts=%0d want 2 2", n_res, n_acc);
    end else begin
      checks++;
      if (acc_cyc[1] - acc_cyc[0] != IN_WIDTH + 2) begin
        failures++;
        $display("FAIL b2b_spacing: got %0d want %0d", acc_cyc[1] - acc_cyc[0], IN_WIDTH + 2);
      end
    end
    exp_q.delete();
    step();
  endtask

  task automatic test_reset_abort();
    int pulses;
    do_convert(7'd127, "pre_abort");
    in_valid = 1'b1;
    in_data = 7'd99;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (bcd_out !== '0 || in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_state: bcd=%h ready=%b ov=%b busy=%b want 000 1 0 0",
               bcd_out, in_ready, out_valid, busy);
    end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid === 1'b1) pulses++;
      step();
    end
    checks++;
    if (pulses != 0 || bcd_out !== '0) begin
      failures++;
      $display("FAIL abort_no_pulse: pulses=%0d bcd=%h want 0 000", pulses, bcd_out);
    end
    do_convert(7'd45, "post_abort45");
  endtask

  task automatic test_sweep();
    for (int v = 0; v < (1 << IN_WIDTH); v++) begin
      do_convert(IN_WIDTH'(v), "sweep");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
      do_convert(IN_WIDTH'($urandom), "random");
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_abort();
    test_sweep();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
